// File: rtl/player_bullet_pool_pkg.sv
// -----------------------------------------------------------------------------
// player_bullet_pool_pkg
// Shared constants and types for the player projectile pool.
//   SCREEN_W  : visible playfield width in pixels; live X range is 0..SCREEN_W-1
//   FIRE_KEY  : keycode that requests a shot (spacebar)
//   coord_t   : unsigned 10-bit screen coordinate
//   scoord_t  : signed 12-bit coordinate used for motion math, so that a
//               bullet stepping past either screen edge stays representable
//   next_x()  : one frame of horizontal motion for a live bullet
// -----------------------------------------------------------------------------
package player_bullet_pool_pkg;

  localparam int         COORD_W  = 10;
  localparam int         SCREEN_W = 640;
  localparam logic [7:0] FIRE_KEY = 8'd44;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic signed [11:0] scoord_t;

  // Candidate X for the next frame. The bullet moves SPEED pixels in its own
  // direction; a world scroll drags everything left by SCROLL_STEP.
  function automatic scoord_t next_x(input coord_t x,
                                     input logic   dir,
                                     input logic   scroll,
                                     input int     speed,
                                     input int     scroll_step);
    scoord_t base;
    scoord_t delta;
    scoord_t drift;
    base  = scoord_t'({2'b00, x});
    delta = dir ? scoord_t'(speed) : -scoord_t'(speed);
    drift = scroll ? scoord_t'(scroll_step) : scoord_t'(0);
    return base + delta - drift;
  endfunction

endpackage

// File: rtl/player_bullet_pool_if.sv
// -----------------------------------------------------------------------------
// player_bullet_pool_if
// Bundle between the game logic and the bullet pool.
//   Requests (game -> pool): keycode, play, direction, scroll, playerX,
//                            playerY, hit[NUM_BULLETS]
//   Results  (pool -> game): bX/bY packed 10 bits per slot (slot i at
//                            [10i+9:10i]), active[NUM_BULLETS], fired
// master : game side (drives requests, reads results)
// slave  : pool side (reads requests, drives results)
// -----------------------------------------------------------------------------
interface player_bullet_pool_if #(
  parameter int NUM_BULLETS = 5
);
  import player_bullet_pool_pkg::*;

  logic [7:0]                     keycode;
  logic                           play;
  logic                           direction;
  logic                           scroll;
  coord_t                         playerX;
  coord_t                         playerY;
  logic [NUM_BULLETS-1:0]         hit;

  logic [COORD_W*NUM_BULLETS-1:0] bX;
  logic [COORD_W*NUM_BULLETS-1:0] bY;
  logic [NUM_BULLETS-1:0]         active;
  logic                           fired;

  modport master (
    output keycode, play, direction, scroll, playerX, playerY, hit,
    input  bX, bY, active, fired
  );

  modport slave (
    input  keycode, play, direction, scroll, playerX, playerY, hit,
    output bX, bY, active, fired
  );

endinterface

// File: rtl/player_bullet_pool_slot.sv
// -----------------------------------------------------------------------------
// player_bullet_pool_slot
// One bullet slot: live flag, position and latched direction.
// Ports:
//   frame_clk, Reset : frame clock, synchronous active-high reset
//   i_play           : 0 clears the slot
//   i_spawn          : load a new bullet (only asserted while the slot is free)
//   i_spawn_x/_y/_dir: spawn position and facing
//   i_hit            : collision kill, ignored while the slot is free
//   i_scroll         : world scrolled left this frame
//   o_active/o_x/o_y : registered slot state; X/Y read 0 whenever inactive
// Kill priority: Reset > !play > hit > off-screen > move.
// -----------------------------------------------------------------------------
module player_bullet_pool_slot
  import player_bullet_pool_pkg::*;
#(
  parameter int SPEED        = 4,
  parameter int SCROLL_STEP  = 1,
  parameter int SLOT_SCREEN_W = SCREEN_W
) (
  input  logic   frame_clk,
  input  logic   Reset,
  input  logic   i_play,
  input  logic   i_spawn,
  input  coord_t i_spawn_x,
  input  coord_t i_spawn_y,
  input  logic   i_spawn_dir,
  input  logic   i_hit,
  input  logic   i_scroll,
  output logic   o_active,
  output coord_t o_x,
  output coord_t o_y
);

  logic    r_active;
  coord_t  r_x;
  coord_t  r_y;
  logic    r_dir;

  scoord_t w_nx;
  logic    w_offscreen;

  always_comb begin
    w_nx        = next_x(r_x, r_dir, i_scroll, SPEED, SCROLL_STEP);
    w_offscreen = (w_nx < scoord_t'(0)) || (w_nx >= scoord_t'(SLOT_SCREEN_W));
  end

  // NOTE: state updates use non-blocking assignments so every slot and the
  // pool controller all see the same pre-edge values within a frame.
  always_ff @(posedge frame_clk) begin
    if (Reset || !i_play) begin
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_dir    <= 1'b0;
    end else if (i_spawn) begin
      // Spawn frame applies no motion; the bullet first moves next frame.
      r_active <= 1'b1;
      r_x      <= i_spawn_x;
      r_y      <= i_spawn_y;
      r_dir    <= i_spawn_dir;
    end else if (r_active) begin
      if (i_hit || w_offscreen) begin
        // Retired slots are zeroed so the renderer never sees stale positions.
        r_active <= 1'b0;
        r_x      <= '0;
        r_y      <= '0;
        r_dir    <= 1'b0;
      end else begin
        r_x <= coord_t'(w_nx);
      end
    end
  end

  assign o_active = r_active;
  assign o_x      = r_x;
  assign o_y      = r_y;

endmodule

// File: rtl/player_bullet_pool.sv
// -----------------------------------------------------------------------------
// player_bullet_pool
// Pool of NUM_BULLETS player projectiles updated once per frame.
// Ports:
//   frame_clk : frame-rate clock
//   Reset     : synchronous, active-high reset; overrides everything
//   bus       : player_bullet_pool_if.slave
//                 in : keycode, play, direction, scroll, playerX, playerY, hit
//                 out: bX, bY (packed per slot), active, fired
// A fire request (FIRE_KEY held, play, cooldown ready) spawns into the lowest
// free slot. The cooldown counter saturates at COOLDOWN; a spawn clears it, so
// a held key auto-fires every COOLDOWN+1 frames. All outputs are registered.
// -----------------------------------------------------------------------------
module player_bullet_pool
  import player_bullet_pool_pkg::*;
#(
  parameter int         NUM_BULLETS      = 5,
  parameter int         COOLDOWN         = 10,
  parameter logic [7:0] FIRE_KEY_CODE    = FIRE_KEY,
  parameter int         SPEED            = 4,
  parameter int         SCROLL_STEP      = 1,
  parameter int         Y_OFFSET         = 11,
  parameter int         POOL_SCREEN_W    = SCREEN_W
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  player_bullet_pool_if.slave  bus
);

  localparam int CNT_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COOLDOWN);

  logic [CNT_W-1:0]       r_cnt;
  logic                   r_fired;

  logic                   w_ready;
  logic                   w_req;
  logic [NUM_BULLETS-1:0] w_active;
  logic [NUM_BULLETS-1:0] w_first_free;
  logic                   w_any_free;
  logic                   w_spawn_ok;
  logic [NUM_BULLETS-1:0] w_spawn_vec;
  coord_t                 w_spawn_y;
  coord_t                 w_x [NUM_BULLETS];
  coord_t                 w_y [NUM_BULLETS];

  assign w_ready   = (r_cnt == CNT_MAX);
  assign w_req     = (bus.keycode == FIRE_KEY_CODE) && bus.play && w_ready;
  // Spawn height wraps in 10 bits when the player is near the top.
  assign w_spawn_y = bus.playerY - coord_t'(Y_OFFSET);

  // Lowest-index free slot. A slot hit this frame is still active, so it only
  // becomes allocatable on the following frame.
  // NOTE: every output gets its default first, so no path infers a latch.
  always_comb begin
    w_first_free = '0;
    w_any_free   = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!w_active[i] && !w_any_free) begin
        w_first_free[i] = 1'b1;
        w_any_free      = 1'b1;
      end
    end
  end

  assign w_spawn_ok  = w_req && w_any_free;
  assign w_spawn_vec = w_spawn_ok ? w_first_free : '0;

  // Cooldown: a dropped request (pool full) leaves the counter at CNT_MAX so
  // the shot goes out as soon as a slot frees. Dropping play freezes it.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_fired <= 1'b0;
    end else begin
      r_fired <= w_spawn_ok;
      if (bus.play) begin
        if (w_spawn_ok) begin
          r_cnt <= '0;
        end else if (!w_ready) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    player_bullet_pool_slot #(
      .SPEED         (SPEED),
      .SCROLL_STEP   (SCROLL_STEP),
      .SLOT_SCREEN_W (POOL_SCREEN_W)
    ) u_slot (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .i_play      (bus.play),
      .i_spawn     (w_spawn_vec[i]),
      .i_spawn_x   (bus.playerX),
      .i_spawn_y   (w_spawn_y),
      .i_spawn_dir (bus.direction),
      .i_hit       (bus.hit[i]),
      .i_scroll    (bus.scroll),
      .o_active    (w_active[i]),
      .o_x         (w_x[i]),
      .o_y         (w_y[i])
    );

    assign bus.bX[COORD_W*i +: COORD_W] = w_x[i];
    assign bus.bY[COORD_W*i +: COORD_W] = w_y[i];
  end

  assign bus.active = w_active;
  assign bus.fired  = r_fired;

endmodule

// File: tb/tb_player_bullet_pool.sv
// -----------------------------------------------------------------------------
// tb_player_bullet_pool
// Self-checking bench for player_bullet_pool. A behavioural model predicts the
// registered outputs for each frame; the prediction is queued before the edge
// and compared after it. Directed checks against fixed values cover spawn,
// motion, edge retirement, scrolling, play drop, reset and hit/fire overlap.
// -----------------------------------------------------------------------------
module tb_player_bullet_pool;

  localparam int NB  = 5;
  localparam int CD  = 10;
  localparam int SPD = 4;
  localparam int SS  = 1;
  localparam int YO  = 11;
  localparam int SW  = 640;

  typedef struct {
    logic [NB-1:0]    act;
    logic [10*NB-1:0] bx;
    logic [10*NB-1:0] by;
    logic             fired;
  } exp_t;

  logic frame_clk;
  logic Reset;

  player_bullet_pool_if #(.NUM_BULLETS(NB)) bus ();

  player_bullet_pool #(
    .NUM_BULLETS (NB),
    .COOLDOWN    (CD),
    .SPEED       (SPD),
    .SCROLL_STEP (SS),
    .Y_OFFSET    (YO)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  // Behavioural model state.
  int m_act [NB];
  int m_x   [NB];
  int m_y   [NB];
  int m_dir [NB];
  int m_cnt;
  int m_fired;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_slot(input int i);
    m_act[i] = 0;
    m_x[i]   = 0;
    m_y[i]   = 0;
    m_dir[i] = 0;
  endtask

  // Advance the model by one frame using the inputs currently applied.
  task automatic model_step();
    int sel;
    int nx;
    bit req;
    if (Reset) begin
      for (int i = 0; i < NB; i++) clear_slot(i);
      m_cnt   = 0;
      m_fired = 0;
    end else if (!bus.play) begin
      for (int i = 0; i < NB; i++) clear_slot(i);
      m_fired = 0;
    end else begin
      req = (bus.keycode == 8'd44) && (m_cnt == CD);
      sel = -1;
      for (int i = 0; i < NB; i++)
        if (sel < 0 && m_act[i] == 0) sel = i;
      for (int i = 0; i < NB; i++) begin
        if (req && i == sel) begin
          m_act[i] = 1;
          m_x[i]   = int'(bus.playerX);
          m_y[i]   = (int'(bus.playerY) - YO + 1024) % 1024;
          m_dir[i] = int'(bus.direction);
        end else if (m_act[i] != 0) begin
          if (bus.hit[i]) begin
            clear_slot(i);
          end else begin
            nx = m_x[i] + ((m_dir[i] != 0) ? SPD : -SPD) - (bus.scroll ? SS : 0);
            if (nx < 0 || nx >= SW) clear_slot(i);
            else m_x[i] = nx;
          end
        end
      end
      m_fired = (req && sel >= 0) ? 1 : 0;
      if (m_fired != 0) m_cnt = 0;
      else if (m_cnt < CD) m_cnt++;
    end
  endtask

  // One frame: predict, queue, clock, then compare the registered outputs.
  task automatic frame();
    exp_t e;
    exp_t got_e;
    model_step();
    for (int i = 0; i < NB; i++) begin
      e.act[i]          = (m_act[i] != 0);
      e.bx[10*i +: 10]  = 10'(m_x[i]);
      e.by[10*i +: 10]  = 10'(m_y[i]);
    end
    e.fired = (m_fired != 0);
    sb_q.push_back(e);
    @(posedge frame_clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      got_e = sb_q.pop_front();
      check("sb_active", 64'(bus.active), 64'(got_e.act));
      check("sb_bx",     64'(bus.bX),     64'(got_e.bx));
      check("sb_by",     64'(bus.bY),     64'(got_e.by));
      check("sb_fired",  64'(bus.fired),  64'(got_e.fired));
    end
  endtask

  task automatic reset_frame();
    Reset = 1'b1;
    frame();
    Reset = 1'b0;
  endtask

  // Hold the fire key until the model predicts a spawn (bounded), then release.
  task automatic fire_when_ready(input string tag);
    bus.keycode = 8'd44;
    for (int k = 0; k < 30; k++) begin
      frame();
      if (m_fired != 0) break;
    end
    bus.keycode = 8'd0;
    check({tag, "_fired"}, 64'(bus.fired), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset         = 1'b1;
    bus.keycode   = 8'd0;
    bus.play      = 1'b1;
    bus.direction = 1'b1;
    bus.scroll    = 1'b0;
    bus.playerX   = 10'd100;
    bus.playerY   = 10'd200;
    bus.hit       = '0;

    // Reset state, then auto-fire with the key held.
    reset_frame();
    check("reset_active", 64'(bus.active), 64'd0);
    check("reset_fired",  64'(bus.fired),  64'd0);
    bus.keycode = 8'd44;
    for (int f = 1; f <= 68; f++) begin
      bus.hit = (f == 67) ? 5'b00100 : 5'b00000;
      frame();
      case (f)
        10: check("no_fire_before_edge11", 64'(bus.fired), 64'd0);
        11: begin
          check("first_fire",  64'(bus.fired),     64'd1);
          check("spawn_x",     64'(bus.bX[9:0]),   64'd100);
          check("spawn_y",     64'(bus.bY[9:0]),   64'd189);
        end
        12: begin
          check("move_x",      64'(bus.bX[9:0]),   64'd104);
          check("one_shot",    64'(bus.fired),     64'd0);
        end
        22: check("slot1_spawn", 64'(bus.active), 64'b00011);
        55: check("pool_full",   64'(bus.active), 64'b11111);
        66: check("drop_when_full", 64'(bus.fired), 64'd0);
        67: check("hit_clears_slot2", 64'(bus.active), 64'b11011);
        68: begin
          check("refill_fired", 64'(bus.fired),      64'd1);
          check("refill_slot2", 64'(bus.bX[29:20]),  64'd100);
          check("refill_full",  64'(bus.active),     64'b11111);
        end
        default: ;
      endcase
    end
    bus.keycode = 8'd0;
    bus.hit     = '0;

    // Left edge retirement.
    reset_frame();
    bus.direction = 1'b0;
    bus.playerX   = 10'd6;
    fire_when_ready("left");
    check("left_spawn_x", 64'(bus.bX[9:0]), 64'd6);
    frame();
    check("left_x2", 64'(bus.bX[9:0]), 64'd2);
    frame();
    check("left_retire_act", 64'(bus.active[0]), 64'd0);
    check("left_retire_x",   64'(bus.bX[9:0]),   64'd0);

    // Right edge retirement.
    bus.direction = 1'b1;
    bus.playerX   = 10'd636;
    fire_when_ready("right");
    check("right_spawn_x", 64'(bus.bX[9:0]), 64'd636);
    frame();
    check("right_retire_act", 64'(bus.active[0]), 64'd0);
    check("right_retire_x",   64'(bus.bX[9:0]),   64'd0);

    // Scrolling drags a right-moving bullet back by one pixel per frame.
    bus.playerX = 10'd300;
    fire_when_ready("scroll");
    bus.scroll = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      frame();
      check("scroll_x", 64'(bus.bX[9:0]), 64'(300 + 3 * k));
    end
    bus.scroll = 1'b0;

    // Play drop clears the pool and freezes the cooldown.
    reset_frame();
    bus.playerX = 10'd100;
    fire_when_ready("p0");
    fire_when_ready("p1");
    fire_when_ready("p2");
    check("three_live", 64'(bus.active), 64'b00111);
    for (int k = 0; k < CD; k++) frame();
    bus.keycode = 8'd44;
    bus.play    = 1'b0;
    frame();
    check("play_drop_active", 64'(bus.active), 64'd0);
    check("play_drop_fired",  64'(bus.fired),  64'd0);
    check("play_drop_bx",     64'(bus.bX),     64'd0);
    bus.play = 1'b1;
    frame();
    check("cooldown_held_fire", 64'(bus.fired),  64'd1);
    check("cooldown_held_slot", 64'(bus.active), 64'b00001);
    bus.keycode = 8'd0;

    // Reset with three live bullets and the fire key held.
    fire_when_ready("r1");
    fire_when_ready("r2");
    check("three_live_again", 64'(bus.active), 64'b00111);
    bus.keycode = 8'd44;
    reset_frame();
    check("reset_mid_active", 64'(bus.active), 64'd0);
    check("reset_mid_bx",     64'(bus.bX),     64'd0);
    check("reset_mid_by",     64'(bus.bY),     64'd0);
    check("reset_mid_fired",  64'(bus.fired),  64'd0);
    bus.keycode = 8'd0;

    // Hit on slot0 and a fire request in the same frame; hit on free slot4
    // is ignored.
    fire_when_ready("hf");
    for (int k = 0; k < 20 && m_cnt != CD; k++) frame();
    bus.keycode = 8'd44;
    bus.hit     = 5'b10001;
    frame();
    bus.hit     = '0;
    bus.keycode = 8'd0;
    check("hitfire_active", 64'(bus.active),     64'b00010);
    check("hitfire_slot1",  64'(bus.bX[19:10]),  64'd100);
    check("hitfire_slot0",  64'(bus.bX[9:0]),    64'd0);
    check("hitfire_fired",  64'(bus.fired),      64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
